// File: rtl/hpb_cfg_rx_sync.sv
// -----------------------------------------------------------------------------
// hpb_cfg_rx_sync
//
// Receive side of the host configuration path, living in the core clock
// domain. The host drives a 4-phase req/ack handshake and holds async_data
// stable for as long as async_req is high. async_req is passed through a
// SYNC_STAGES flop chain. A rising synchronised request captures async_data
// into a small FIFO, and the FIFO is presented to the strategy core as a
// valid/accept stream.
//
// Ports:
//   clk               core clock
//   reset_n           asynchronous active-low reset (all flops, incl. sync chain)
//   async_req         host request level, unsynchronised
//   async_data        host data, stable while async_req=1 (never synchronised)
//   async_ack         registered ack level back to the host domain
//   out_config_valid  FIFO non-empty
//   out_config_data   FIFO head word
//   out_config_accept core consumes the head when valid & accept
//   fifo_level        current occupancy, 0..DEPTH
//   xfer_count        completed captures, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module hpb_cfg_rx_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,   // legal 2..4
  parameter int DEPTH       = 4,   // power of 2, >= 2
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       async_req,
  input  logic [DATA_WIDTH-1:0]      async_data,
  output logic                       async_ack,
  output logic                       out_config_valid,
  output logic [DATA_WIDTH-1:0]      out_config_data,
  input  logic                       out_config_accept,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       xfer_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Request synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   ack_q, ack_d;
  logic   push;
  logic   pop;

  logic [LVL_W-1:0] level_q, level_d;

  // Full check looks at the registered level only: a pop in the same cycle
  // does not free a slot for this edge's capture.
  logic fifo_full;
  assign fifo_full = (level_q == LVL_W'(DEPTH));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_s && !fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        // Only a synchronised low request returns to IDLE, so one handshake
        // can produce at most one capture.
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Accept on an empty FIFO is ignored.
  assign pop = (level_q != '0) && out_config_accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    // Pointers are PTR_W bits wide and DEPTH is a power of 2, so the
    // increment wraps DEPTH-1 -> 0 by itself.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;  // idle, or push and pop together
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array is reset as well, because the head word
  // out_config_data has to read 0 straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= async_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all from registered state, no input-to-output paths
  // ---------------------------------------------------------------------------
  assign async_ack        = ack_q;
  assign out_config_valid = (level_q != '0);
  assign out_config_data  = mem_q[rd_ptr_q];
  assign fifo_level       = level_q;
  assign xfer_count       = cnt_q;

endmodule
